// File: rtl/conv_window_pkg.sv
// Shared widths and FSM encoding for the 3x3 window reader.
package conv_window_pkg;
  localparam int PIX_W  = 8;
  localparam int IMG_W  = 416;
  localparam int PAD_W  = IMG_W + 2;
  localparam int ROW_W  = PAD_W * PIX_W;
  localparam int WIN_W  = 9 * PIX_W;
  localparam int COL_W  = 9;
  localparam int NUM_CH = 3;
  localparam int BIT_W  = $clog2(ROW_W);

  typedef enum logic {IDLE, STREAM} state_t;
endpackage

// File: rtl/window_slice.sv
// Combinational 3x3 window extraction for one channel at a given column.
module window_slice
  import conv_window_pkg::*;
(
  input  logic [2:0][ROW_W-1:0] i_rows,
  input  logic [COL_W-1:0]      i_col,
  output logic [WIN_W-1:0]      o_win
);
  logic [BIT_W-1:0] w_base;

  always_comb begin
    o_win  = '0;
    w_base = '0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        w_base = BIT_W'((int'(i_col) + c) * PIX_W);
        o_win[(r*3+c)*PIX_W +: PIX_W] = i_rows[r][w_base +: PIX_W];
      end
    end
  end
endmodule

// File: rtl/conv_window_reader.sv
// Snapshots a padded R/G/B row set and streams 416 3x3 windows with valid/ready.
module conv_window_reader
  import conv_window_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [ROW_W-1:0] R_row0,
  input  logic [ROW_W-1:0] R_row1,
  input  logic [ROW_W-1:0] R_row2,
  input  logic [ROW_W-1:0] G_row0,
  input  logic [ROW_W-1:0] G_row1,
  input  logic [ROW_W-1:0] G_row2,
  input  logic [ROW_W-1:0] B_row0,
  input  logic [ROW_W-1:0] B_row1,
  input  logic [ROW_W-1:0] B_row2,
  input  logic             rows_valid,
  output logic             rows_ready,
  output logic [WIN_W-1:0] R_win,
  output logic [WIN_W-1:0] G_win,
  output logic [WIN_W-1:0] B_win,
  output logic             win_valid,
  input  logic             win_ready,
  output logic [COL_W-1:0] win_col,
  output logic             win_last
);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_W - 1);

  state_t r_state, w_next;
  logic [COL_W-1:0] r_col;
  logic [NUM_CH-1:0][2:0][ROW_W-1:0] r_snap, w_rows;
  logic [NUM_CH-1:0][WIN_W-1:0] w_win;
  logic w_clr, w_load, w_adv;

  assign w_clr     = reset || !en;
  assign w_rows[0] = {R_row2, R_row1, R_row0};
  assign w_rows[1] = {G_row2, G_row1, G_row0};
  assign w_rows[2] = {B_row2, B_row1, B_row0};

  always_ff @(posedge clk) begin
    if (w_clr) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    rows_ready = 1'b0;
    win_valid  = 1'b0;
    w_load     = 1'b0;
    w_adv      = 1'b0;
    case (r_state)
      IDLE: begin
        rows_ready = !w_clr;
        if (rows_valid && !w_clr) begin
          w_load = 1'b1;
          w_next = STREAM;
        end
      end
      STREAM: begin
        win_valid = 1'b1;
        if (win_ready) begin
          w_adv = 1'b1;
          if (r_col == LAST_COL) w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Column returns to 0 after the last window so win_col idles at 0.
  always_ff @(posedge clk) begin
    if (w_clr) begin
      r_col  <= '0;
      r_snap <= '0;
    end else if (w_load) begin
      r_col  <= '0;
      r_snap <= w_rows;
    end else if (w_adv) begin
      r_col <= (r_col == LAST_COL) ? '0 : r_col + 1'b1;
    end
  end

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    window_slice u_slice (
      .i_rows (r_snap[ch]),
      .i_col  (r_col),
      .o_win  (w_win[ch])
    );
  end

  assign R_win    = win_valid ? w_win[0] : '0;
  assign G_win    = win_valid ? w_win[1] : '0;
  assign B_win    = win_valid ? w_win[2] : '0;
  assign win_col  = r_col;
  assign win_last = win_valid && (r_col == LAST_COL);
endmodule

// File: tb/tb_conv_window_reader.sv
// Randomized bench for conv_window_reader against a transaction-level row-set model.
module tb_conv_window_reader;
  logic clk = 0, reset = 1, en = 1, rows_valid = 0, win_ready = 0;
  logic [3343:0] rows [3][3];
  logic rows_ready, win_valid, win_last;
  logic [71:0] R_win, G_win, B_win;
  logic [8:0] win_col;

  int n_chk = 0, n_err = 0, cyc = 0, n_win = 0;
  int acc_q[$];
  logic [7:0] snap [3][3][418];
  bit m_stream = 0;
  int m_col = 0;

  always #5 clk = ~clk;

  conv_window_reader dut (
    .clk(clk), .reset(reset), .en(en),
    .R_row0(rows[0][0]), .R_row1(rows[0][1]), .R_row2(rows[0][2]),
    .G_row0(rows[1][0]), .G_row1(rows[1][1]), .G_row2(rows[1][2]),
    .B_row0(rows[2][0]), .B_row1(rows[2][1]), .B_row2(rows[2][2]),
    .rows_valid(rows_valid), .rows_ready(rows_ready),
    .R_win(R_win), .G_win(G_win), .B_win(B_win),
    .win_valid(win_valid), .win_ready(win_ready),
    .win_col(win_col), .win_last(win_last)
  );

  task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [71:0] exp_win(int ch, int col);
    logic [71:0] w = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        w[(r*3+c)*8 +: 8] = snap[ch][r][col+c];
    return w;
  endfunction

  // Reference: a row set yields windows at columns 0..415 in order, one per accept.
  initial forever begin
    @(negedge clk);
    cyc++;
    if (cyc > 1) begin
      chk("rows_ready", rows_ready, !reset && en && !m_stream);
      chk("win_valid",  win_valid, m_stream);
      chk("win_col",    win_col, m_stream ? m_col : 0);
      chk("win_last",   win_last, m_stream && m_col == 415);
      chk("R_win", R_win, m_stream ? exp_win(0, m_col) : '0);
      chk("G_win", G_win, m_stream ? exp_win(1, m_col) : '0);
      chk("B_win", B_win, m_stream ? exp_win(2, m_col) : '0);
    end
    if (win_valid && win_ready) n_win++;
    if (rows_valid && rows_ready) acc_q.push_back(cyc);
    if (reset || !en) begin
      m_stream = 0; m_col = 0;
    end else if (!m_stream) begin
      if (rows_valid) begin
        for (int ch = 0; ch < 3; ch++)
          for (int r = 0; r < 3; r++)
            for (int k = 0; k < 418; k++)
              snap[ch][r][k] = rows[ch][r][k*8 +: 8];
        m_stream = 1; m_col = 0;
      end
    end else if (win_ready) begin
      if (m_col == 415) m_stream = 0;
      else m_col++;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic fill(input bit rnd);
    for (int ch = 0; ch < 3; ch++)
      for (int r = 0; r < 3; r++)
        for (int k = 0; k < 418; k++)
          rows[ch][r][k*8 +: 8] = rnd ? 8'($urandom) : 8'(k);
  endtask

  task automatic wait_col(input int col);
    int n = 0;
    while (win_col != 9'(col) && n < 600) begin tick(); n++; end
    chk("reach_col", win_col, col);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (win_valid && n < 4000) begin tick(); n++; end
    chk("stream_end", win_valid, 0);
  endtask

  task automatic load(input bit rnd);
    fill(rnd); rows_valid = 1; tick(); rows_valid = 0;
  endtask

  initial begin
    int n0, a0, held;
    logic [71:0] cap;
    for (int ch = 0; ch < 3; ch++) for (int r = 0; r < 3; r++) rows[ch][r] = '0;
    repeat (3) tick();
    chk("rst_rows_ready", rows_ready, 0);
    reset = 0;
    tick();
    chk("idle_rows_ready", rows_ready, 1);
    chk("idle_win", {R_win[23:0], G_win[23:0], B_win[23:0]}, 0);

    // Ramp pixels, full throughput.
    win_ready = 1;
    n0 = n_win;
    load(0);
    chk("col0_e00", R_win[7:0], 0);
    chk("col0_e22", R_win[71:64], 2);
    wait_col(415);
    chk("col415_e12", R_win[47:40], 161);
    chk("col415_last", win_last, 1);
    tick();
    chk("after_last_ready", rows_ready, 1);
    chk("win_count", n_win - n0, 416);

    // Random data, random backpressure, hold at col 10, row churn mid-stream.
    load(1);
    held = 0;
    for (int n = 0; n < 4000 && win_valid; n++) begin
      if (win_col == 10 && !held) begin
        held = 1;
        win_ready = 0;
        cap = R_win;
        repeat (5) begin
          tick();
          chk("bp_col", win_col, 10);
          chk("bp_win", R_win, cap);
        end
        win_ready = 1;
        tick();
        chk("bp_resume", win_col, 11);
      end else begin
        win_ready = ($urandom_range(0, 9) < 7);
        if (n % 7 == 3) fill(1);
        rows_valid = (win_col < 400) ? 1'($urandom) : 1'b0;
        tick();
      end
    end
    rows_valid = 0;
    win_ready = 1;
    wait_idle();

    // Abort with reset, then with en low.
    load(0);
    wait_col(200);
    reset = 1; tick();
    chk("rst_abort_valid", win_valid, 0);
    chk("rst_abort_win", R_win, 0);
    reset = 0;
    load(1);
    chk("restart_col", win_col, 0);
    chk("restart_valid", win_valid, 1);
    wait_col(50);
    en = 0; tick();
    chk("en_abort_valid", win_valid, 0);
    chk("en_low_ready", rows_ready, 0);
    en = 1; tick();
    chk("en_back_ready", rows_ready, 1);

    // Back-to-back row sets.
    a0 = acc_q.size();
    fill(1);
    rows_valid = 1;
    repeat (900) tick();
    rows_valid = 0;
    chk("b2b_count", acc_q.size() - a0, 3);
    if (acc_q.size() - a0 >= 3) begin
      chk("b2b_period1", acc_q[a0+1] - acc_q[a0], 417);
      chk("b2b_period2", acc_q[a0+2] - acc_q[a0+1], 417);
    end
    wait_idle();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
